alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Multi-cycle execution responder for the 3-bit ALU opcode set: ADD, OR, XOR, AND, LT, EQ, SLL, SRL.
- Accepts one operation per request over a valid/ready handshake and returns the result with carry and zero flags over a second valid/ready handshake.
- Sits between the control/decode stage, which issues the opcodes, and register writeback.
- Logic ops complete in one cycle; shifts use an iterative one-bit-per-cycle shifter to save area.

Parameters:
- W, 8, datapath width in bits; must be a power of 2 and at least 2.
- SW, $clog2(W), shift-amount width; the shift amount is taken from InB[SW-1:0].

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  unit can accept a request.
- ReqOp  in  3  opcode: 000 ADD, 001 OR, 010 XOR, 011 AND, 100 LT, 101 EQ, 110 SLL, 111 SRL.
- InA  in  W  operand A.
- InB  in  W  operand B; for shifts, only InB[SW-1:0] is used.
- RspValid  out  1  result present.
- RspReady  in  1  consumer takes the result.
- RspOut  out  W  result.
- RspCarry  out  1  carry / shifted-out bit.
- RspZero  out  1  1 when RspOut equals 0.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-low: Reset_n sampled low at a rising edge of Clk resets the block.
- Reset:
  - Next state is IDLE.
  - ReqReady=1, RspValid=0, RspOut=0, RspCarry=0, RspZero=0.
  - The shift counter and all latched operands are cleared.
  - Reset has priority over every other event, including mid-shift and while a result is pending; the in-flight operation is dropped with no response.
- States: IDLE, SHIFT, DONE. ReqReady=1 only in IDLE. RspValid=1 only in DONE.
- IDLE:
  - A handshake occurs when ReqValid=1 at a rising edge; ReqOp, InA and InB are latched.
  - For SLL or SRL with a nonzero amount: accumulator <= InA, counter <= amount, next state SHIFT.
  - Otherwise the result is computed and registered, and the next state is DONE, so RspValid rises 1 cycle after acceptance.
- SHIFT, once per cycle:
  - SLL: carry <= acc[W-1] and acc <= acc<<1.
  - SRL: carry <= acc[0] and acc <= acc>>1.
  - counter decrements by 1; when it reaches 0 the next state is DONE.
  - Total latency from acceptance to RspValid is 1+amount cycles.
- DONE:
  - RspOut, RspCarry and RspZero are held stable while RspValid=1 and RspReady=0.
  - When RspReady=1 at an edge the next state is IDLE, so ReqReady rises on the following cycle. There is no same-cycle bypass; the minimum issue interval is 2 cycles.
- Arithmetic (all unsigned, width W):
  - ADD: RspOut = (A+B) mod 2^W; RspCarry = carry out of bit W-1.
  - OR / XOR / AND: bitwise; RspCarry=0.
  - LT: RspOut = 1 if A<B, else 0, zero-extended to W; RspCarry=0.
  - EQ: RspOut = 1 if A==B, else 0, zero-extended to W; RspCarry=0.
  - SLL / SRL with amount 0: RspOut=A, RspCarry=0, latency 1.
  - SLL / SRL with nonzero amount: RspCarry is the last bit shifted out.
  - RspZero = (RspOut == 0) for every op.
- Boundary conditions:
  - ReqValid while the unit is busy (SHIFT or DONE) is ignored, since ReqReady=0. The requester must hold ReqValid and its operands until the handshake.
  - RspReady asserted outside DONE has no effect.
  - Operand inputs changing after acceptance do not affect the result.
  - All 8 opcodes are defined; there is no illegal-op path.

Test Plan:
- ADD 0xF0+0x20, RspReady=1 -> RspValid asserted 1 cycle after acceptance; RspOut=0x10, RspCarry=1, RspZero=0; ReqReady=1 the cycle after the response handshake.
- SLL A=0xC1, B=0x02 -> RspValid 3 cycles after acceptance; RspOut=0x04, RspCarry=1. Then SRL A=0x05, B=0x02 -> RspOut=0x01, RspCarry=0.
- XOR 0xAA^0xAA, with RspReady held 0 for 5 cycles and ReqValid with ADD held high throughout -> RspOut=0x00, RspZero=1 stable for all 5 cycles; ReqReady=0 and the second request is not accepted until after the response handshake.
- LT 0x7F vs 0x80 -> 0x01. LT 0x80 vs 0x7F -> 0x00 with RspZero=1. EQ 0x33 vs 0x33 -> 0x01. SLL A=0x9C, B=0x08 (amount 0 for W=8) -> 0x9C, RspCarry=0, latency 1.
- SRL A=0xFF, B=0x07, with Reset_n low at the 3rd SHIFT cycle -> next cycle: ReqReady=1, RspValid=0, all outputs 0, no response ever issued. A subsequent AND 0x0F&0x3C -> 0x0C.

Source files
------------

// File: rtl/alu_seq_unit_if.sv
// rtl/alu_seq_unit_if.sv - request/response handshake bundle for alu_seq_unit
interface alu_seq_unit_if #(
  parameter int W = 8
);
  logic         ReqValid;
  logic         ReqReady;
  logic [2:0]   ReqOp;
  logic [W-1:0] InA;
  logic [W-1:0] InB;
  logic         RspValid;
  logic         RspReady;
  logic [W-1:0] RspOut;
  logic         RspCarry;
  logic         RspZero;

  // Requester side: issues operations and consumes results.
  modport master (
    output ReqValid, ReqOp, InA, InB, RspReady,
    input  ReqReady, RspValid, RspOut, RspCarry, RspZero
  );

  // Execution unit side.
  modport slave (
    input  ReqValid, ReqOp, InA, InB, RspReady,
    output ReqReady, RspValid, RspOut, RspCarry, RspZero
  );
endinterface

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - multi-cycle ALU responder with iterative one-bit shifter
module alu_seq_unit #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic         Clk,
  input  logic         Reset_n,
  alu_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_EQ  = 3'b101;

  state_t        r_state;
  logic [W-1:0]  r_acc;       // shift accumulator, then the held result
  logic [SW-1:0] r_cnt;       // remaining shift steps
  logic          r_dir_right; // 1 = SRL, 0 = SLL
  logic          r_carry;
  logic          r_zero;
  logic          r_req_ready;
  logic          r_rsp_valid;

  logic [W:0]    w_sum;
  logic [W-1:0]  w_res;
  logic          w_car;
  logic [SW-1:0] w_amt;
  logic          w_is_shift;
  logic [W-1:0]  w_acc_next;
  logic          w_shift_out;

  assign w_amt      = bus.InB[SW-1:0];
  assign w_is_shift = bus.ReqOp[2] & bus.ReqOp[1];

  // Single-cycle result for every op that does not need the iterative shifter.
  always_comb begin
    w_sum = {1'b0, bus.InA} + {1'b0, bus.InB};
    w_res = '0;
    w_car = 1'b0;
    case (bus.ReqOp)
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_car = w_sum[W];
      end
      OP_OR:   w_res = bus.InA | bus.InB;
      OP_XOR:  w_res = bus.InA ^ bus.InB;
      OP_AND:  w_res = bus.InA & bus.InB;
      OP_LT:   w_res = {{(W-1){1'b0}}, (bus.InA < bus.InB)};
      OP_EQ:   w_res = {{(W-1){1'b0}}, (bus.InA == bus.InB)};
      default: w_res = bus.InA;  // shift by zero passes A through
    endcase
  end

  // One step of the shifter in the latched direction.
  always_comb begin
    w_acc_next  = r_dir_right ? (r_acc >> 1) : (r_acc << 1);
    w_shift_out = r_dir_right ? r_acc[0] : r_acc[W-1];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_dir_right <= 1'b0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ReqValid) begin
            r_req_ready <= 1'b0;
            if (w_is_shift && (w_amt != '0)) begin
              r_acc       <= bus.InA;
              r_cnt       <= w_amt;
              r_dir_right <= bus.ReqOp[0];
              r_carry     <= 1'b0;
              r_state     <= S_SHIFT;
            end else begin
              r_acc       <= w_res;
              r_carry     <= w_car;
              r_zero      <= (w_res == '0);
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_acc   <= w_acc_next;
          r_carry <= w_shift_out;
          r_cnt   <= r_cnt - SW'(1);
          if (r_cnt == SW'(1)) begin
            r_zero      <= (w_acc_next == '0);
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.RspReady) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ReqReady = r_req_ready;
  assign bus.RspValid = r_rsp_valid;
  assign bus.RspOut   = r_acc;
  assign bus.RspCarry = r_carry;
  assign bus.RspZero  = r_zero;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - randomized and directed bench for alu_seq_unit
module tb_alu_seq_unit;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  alu_seq_unit_if #(.W(W)) bus ();

  alu_seq_unit #(.W(W)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic chk_en    = 1'b0;

  typedef struct packed {
    logic [7:0] res;
    logic       car;
    logic [7:0] lat;
  } ref_t;

  // Reference result from the opcode definitions using plain integer arithmetic.
  function automatic ref_t ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    ref_t r;
    int ia, ib, amt;
    ia  = int'(a);
    ib  = int'(b);
    amt = ib % W;
    r.car = 1'b0;
    r.lat = 8'd1;
    case (op)
      3'd0: begin
        r.res = 8'((ia + ib) % 256);
        r.car = (ia + ib) >= 256;
      end
      3'd1: r.res = a | b;
      3'd2: r.res = a ^ b;
      3'd3: r.res = a & b;
      3'd4: r.res = (ia < ib) ? 8'd1 : 8'd0;
      3'd5: r.res = (ia == ib) ? 8'd1 : 8'd0;
      3'd6: begin
        if (amt == 0) r.res = a;
        else begin
          r.res = 8'((ia * (1 << amt)) % 256);
          r.car = ((ia / (1 << (W - amt))) % 2) == 1;
          r.lat = 8'(1 + amt);
        end
      end
      default: begin
        if (amt == 0) r.res = a;
        else begin
          r.res = 8'(ia / (1 << amt));
          r.car = ((ia / (1 << (amt - 1))) % 2) == 1;
          r.lat = 8'(1 + amt);
        end
      end
    endcase
    return r;
  endfunction

  ref_t w_ref;
  assign w_ref = ref_op(bus.ReqOp, bus.InA, bus.InB);

  // Transaction-level model: busy flag, countdown to the response, held result.
  logic       m_busy, m_valid, m_clear, m_carry;
  logic [7:0] m_out;
  int         m_wait;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_clear <= 1'b1;
      m_out   <= 8'h00;
      m_carry <= 1'b0;
      m_wait  <= 0;
    end else if (!m_busy) begin
      if (bus.ReqValid) begin
        m_busy  <= 1'b1;
        m_clear <= 1'b0;
        m_out   <= w_ref.res;
        m_carry <= w_ref.car;
        m_valid <= (w_ref.lat == 8'd1);
        m_wait  <= int'(w_ref.lat) - 1;
      end
    end else if (!m_valid) begin
      if (m_wait == 1) m_valid <= 1'b1;
      m_wait <= m_wait - 1;
    end else if (bus.RspReady) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end
  end

  task automatic check_cycle();
    logic ok;
    if (!chk_en) return;
    vectors++;
    ok = (bus.ReqReady === !m_busy) && (bus.RspValid === m_valid);
    if (m_valid)
      ok = ok && (bus.RspOut === m_out) && (bus.RspCarry === m_carry) && (bus.RspZero === (m_out == 8'h00));
    if (m_clear)
      ok = ok && (bus.RspOut === 8'h00) && (bus.RspCarry === 1'b0) && (bus.RspZero === 1'b0);
    if (!ok) begin
      miscompares++;
      $display("FAIL cycle t=%0t ready=%b want %b valid=%b want %b out=%h want %h carry=%b want %b zero=%b",
               $time, bus.ReqReady, !m_busy, bus.RspValid, m_valid, bus.RspOut, m_out,
               bus.RspCarry, m_carry, bus.RspZero);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Issue one op, wait for its response, optionally hold off the consumer.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input logic pend_add,
                       input logic lit_en, input logic [7:0] l_out, input logic l_car,
                       input logic l_zero, input int l_lat);
    int n, lat;
    ref_t r;
    r = ref_op(op, a, b);
    bus.ReqValid = 1'b1;
    bus.ReqOp    = op;
    bus.InA      = a;
    bus.InB      = b;
    n = 0;
    while (!bus.ReqReady && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) lit("accept_timeout", 32'(n), 32'd0);
    tick();
    if (pend_add) begin
      bus.ReqOp = 3'd0;
      bus.InA   = 8'h12;
      bus.InB   = 8'h34;
    end else begin
      bus.ReqValid = 1'b0;
      bus.ReqOp    = 3'($urandom);
      bus.InA      = 8'($urandom);
      bus.InB      = 8'($urandom);
    end
    lat = 1;
    while (!bus.RspValid && lat < 40) begin
      bus.RspReady = 1'($urandom);
      tick();
      lat++;
    end
    lit("latency", 32'(lat), 32'(r.lat));
    if (lit_en) begin
      lit("rsp_out", 32'(bus.RspOut), 32'(l_out));
      lit("rsp_carry", 32'(bus.RspCarry), 32'(l_car));
      lit("rsp_zero", 32'(bus.RspZero), 32'(l_zero));
      lit("lit_latency", 32'(lat), 32'(l_lat));
    end
    for (int h = 0; h < hold; h++) begin
      bus.RspReady = 1'b0;
      tick();
      lit("busy_ready", 32'(bus.ReqReady), 32'd0);
      if (lit_en) lit("held_out", 32'(bus.RspOut), 32'(l_out));
    end
    bus.RspReady = 1'b1;
    tick();
    bus.RspReady = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.ReqValid = 1'b0;
    bus.ReqOp    = 3'd0;
    bus.InA      = 8'h00;
    bus.InB      = 8'h00;
    bus.RspReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    tick();
    lit("reset_ready", 32'(bus.ReqReady), 32'd1);
    lit("reset_valid", 32'(bus.RspValid), 32'd0);
    rst_n = 1'b1;
    tick();

    do_op(3'd0, 8'hF0, 8'h20, 0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1);
    lit("ready_after_rsp", 32'(bus.ReqReady), 32'd1);
    do_op(3'd6, 8'hC1, 8'h02, 0, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 3);
    do_op(3'd7, 8'h05, 8'h02, 1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 3);
    do_op(3'd2, 8'hAA, 8'hAA, 5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1);
    do_op(3'd0, 8'h12, 8'h34, 0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0, 1);
    do_op(3'd4, 8'h7F, 8'h80, 0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1);
    do_op(3'd4, 8'h80, 8'h7F, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1);
    do_op(3'd5, 8'h33, 8'h33, 0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1);
    do_op(3'd6, 8'h9C, 8'h08, 0, 1'b0, 1'b1, 8'h9C, 1'b0, 1'b0, 1);

    // SRL by 7 with reset landing on the third shift cycle.
    bus.ReqValid = 1'b1;
    bus.ReqOp    = 3'd7;
    bus.InA      = 8'hFF;
    bus.InB      = 8'h07;
    tick();
    bus.ReqValid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lit("rst_ready", 32'(bus.ReqReady), 32'd1);
    lit("rst_valid", 32'(bus.RspValid), 32'd0);
    lit("rst_out", 32'(bus.RspOut), 32'd0);
    lit("rst_carry", 32'(bus.RspCarry), 32'd0);
    lit("rst_zero", 32'(bus.RspZero), 32'd0);
    for (int i = 0; i < 10; i++) begin
      bus.RspReady = 1'($urandom);
      tick();
    end
    bus.RspReady = 1'b0;
    do_op(3'd3, 8'h0F, 8'h3C, 0, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 1);

    for (int i = 0; i < 60; i++)
      do_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
            1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
